mr16_irqc: RTL
==============

# mr16_irqc

Interrupt controller for the mr16 sub-CPU in the X1 design. It replaces the fixed combinational priority chain in front of the core with a sequenced controller that provides:
- per-source mask and edge/level mode;
- pending latches;
- a request/acknowledge FSM that holds the vector stable until the core acknowledges;
- a one-cycle acknowledge pulse back to the winning source.

It sits on the mr16 I/O bus as a 4-word register block and drives the core's IntReq/IntVector and receives IntAck.

## Interface
- N_SRC, 5, number of interrupt sources; source 0 has the highest priority.
- VEC_BASE, 1, vector issued for source 0; source i issues VEC_BASE+i. VEC_BASE+N_SRC-1 must be ≤ 15.

- I_CLK  in  1  system clock
- I_RESET  in  1  asynchronous, active-high reset
- I_CLKEN  in  1  core clock enable; arbitration steps only on enabled cycles
- I_SRC  in  N_SRC  raw interrupt sources, synchronous to I_CLK
- I_CS  in  1  register block select
- I_WR  in  1  write strobe, qualified by I_CS
- I_A  in  2  word address
- I_D  in  16  write data
- O_D  out  16  registered read data
- O_IRQ  out  1  interrupt request to core
- O_VECTOR  out  4  vector to core; valid while O_IRQ=1
- I_IACK  in  1  core interrupt acknowledge
- O_ACK  out  N_SRC  one-cycle acknowledge pulse to the serviced source

## Operation
- Registers. Only bits [N_SRC-1:0] are used; upper bits write-ignored and read 0.
  - A=0 MASK: 1 = enabled.
  - A=1 MODE: 1 = rising-edge, 0 = level.
  - A=2 PEND: read pending bits; write 1 clears an edge pending bit.
  - A=3 STAT (read-only): bit15 = O_IRQ, bits[3:0] = O_VECTOR, bits[6:4] = FSM state code.
- Edge sources: a rising edge (I_SRC=1 with the previous-cycle sample 0) sets PEND[i]. The bit clears on acknowledge or on a write-1-clear.
- Level sources: PEND[i] follows I_SRC[i] every cycle. Acknowledge and writes have no effect.
- Active set = PEND & MASK. Winner = lowest set index.
- FSM states: IDLE=0, REQ=1, HOLD=2.
  - **IDLE**: on an I_CLKEN cycle with a non-empty active set, latch the winner index, set O_VECTOR=VEC_BASE+idx and O_IRQ=1, go to REQ.
  - **REQ**: the vector is frozen; a higher-priority arrival does not preempt it.
    - I_IACK=1 on any cycle: O_ACK[idx] pulses for exactly one I_CLK, edge PEND[idx] clears, O_IRQ goes to 0, go to HOLD.
    - Otherwise, on an I_CLKEN cycle where active[idx]=0 (masked, cleared, or level dropped): withdraw. O_IRQ goes to 0, O_VECTOR goes to 0, go to IDLE, no ACK.
  - **HOLD**: O_IRQ=0, O_VECTOR=0. Stay until the next I_CLKEN cycle, then go to IDLE. This guarantees the core samples IntReq low for at least one enabled cycle between interrupts.
- Simultaneous events:
  - A new edge on the same cycle as its clear (acknowledge or write-1) leaves PEND set; the edge wins.
  - A register write and an acknowledge on the same cycle both take effect.
- Reset values: all registers 0, edge history 0, state IDLE, O_IRQ=0, O_VECTOR=0, O_ACK=0, O_D=0.
- Reset asserted mid-REQ drops O_IRQ immediately, because the reset is asynchronous.

## Timing
- Edge on I_SRC at clock n → PEND set after edge n+1 → O_IRQ high after the first I_CLKEN edge at or after n+2.
- I_IACK sampled at edge m → O_ACK high for the cycle after m, O_IRQ low after m.
- With I_CLKEN tied high, the minimum gap from O_IRQ falling to the next O_IRQ rising is 2 cycles (HOLD, then IDLE).
- Read latency: O_D is updated on the edge where I_CS&~I_WR is sampled and valid the following cycle. O_D holds its value otherwise.
- Writes take effect on the edge where I_CS&I_WR is sampled. A MASK write to 0 affects the REQ withdraw check at the next I_CLKEN edge.

## Structure
- Package mr16_irqc_pkg holds:
  - FSM state encoding: IDLE, REQ, HOLD.
  - Register address constants: ADDR_MASK=0, ADDR_MODE=1, ADDR_PEND=2, ADDR_STAT=3.
  - Vector width constant: 4.
- One sub-module, mr16_irqc_prio: parameterised, purely combinational lowest-index priority encoder, returns {valid, index}.
- Everything else lives in the top module.

## Test plan
- Reset, then write MASK=0x01 and MODE=0x01, then pulse I_SRC[0] for 1 cycle → O_IRQ=1, O_VECTOR=1. Assert I_IACK → O_ACK=0b00001 for one cycle, PEND reads 0, STAT state=HOLD then IDLE.
- MASK=0x1F, MODE=0x1F, edges on sources 3 and 1 on the same cycle → vector 2 served first. After its acknowledge and HOLD → vector 4 served.
- In REQ with vector 4 (source 3), raise an edge on source 0 → vector stays 4 until acknowledge; next request is vector 1.
- Level source 2 (MODE bit=0, MASK=0x04): I_SRC[2]=1 → O_IRQ with vector 3. Drop I_SRC[2] before acknowledge → O_IRQ returns to 0 on the next I_CLKEN edge, no O_ACK pulse.
- Write PEND=0x01 on the same cycle as a new edge on source 0 → PEND[0] remains 1. Write MASK=0 while in REQ → withdraw to IDLE.
- I_CLKEN=1 every 4th cycle: IDLE→REQ and HOLD→IDLE advance only on enabled cycles. I_RESET asserted during REQ → all outputs 0 immediately.

Source files
------------

// File: rtl/mr16_irqc_pkg.sv
// mr16_irqc_pkg: FSM state encoding, register addresses and vector width for mr16_irqc
package mr16_irqc_pkg;
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_HOLD = 3'd2
   } state_t;
   localparam logic [1:0] ADDR_MASK = 2'd0;
   localparam logic [1:0] ADDR_MODE = 2'd1;
   localparam logic [1:0] ADDR_PEND = 2'd2;
   localparam logic [1:0] ADDR_STAT = 2'd3;
   localparam int VEC_W = 4;
endpackage

// File: rtl/mr16_irqc_prio.sv
// mr16_irqc_prio: combinational lowest-index priority encoder
//   req   in  N   request vector, bit 0 highest priority
//   valid out 1   any request set
//   idx   out IW  index of lowest set bit (0 when none)
module mr16_irqc_prio #(
   parameter int N  = 5,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic          valid,
   output logic [IW-1:0] idx
);
   always_comb begin
      valid = |req;
      idx = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req[i]) idx = IW'(i);
   end
endmodule

// File: rtl/mr16_irqc.sv
// mr16_irqc: sequenced interrupt controller for the mr16 sub-CPU
//   I_CLK, I_RESET (async, active-high), I_CLKEN   clocking
//   I_SRC      raw interrupt sources, bit 0 highest priority
//   I_CS, I_WR, I_A, I_D, O_D   4-word register block (MASK, MODE, PEND, STAT)
//   O_IRQ, O_VECTOR, I_IACK     core request/vector/acknowledge
//   O_ACK      one-cycle acknowledge pulse to the serviced source
module mr16_irqc
   import mr16_irqc_pkg::*;
#(
   parameter int N_SRC    = 5,
   parameter int VEC_BASE = 1
) (
   input  logic               I_CLK,
   input  logic               I_RESET,
   input  logic               I_CLKEN,
   input  logic [N_SRC-1:0]   I_SRC,
   input  logic               I_CS,
   input  logic               I_WR,
   input  logic [1:0]         I_A,
   input  logic [15:0]        I_D,
   output logic [15:0]        O_D,
   output logic               O_IRQ,
   output logic [VEC_W-1:0]   O_VECTOR,
   input  logic               I_IACK,
   output logic [N_SRC-1:0]   O_ACK
);
   localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   state_t state, state_n;
   logic [IW-1:0] idx, idx_n, win;
   logic win_v, wr_en, rd_en, take_ack, unused_d;
   logic [N_SRC-1:0] mask, mode, pend, src_q, active, sel, clr, pend_n;
   logic [15:0] rd_data;
   assign wr_en = I_CS & I_WR;
   assign rd_en = I_CS & ~I_WR;
   assign active = pend & mask;
   assign sel = N_SRC'(1) << idx;
   assign unused_d = ^I_D[15:N_SRC];
   mr16_irqc_prio #(.N(N_SRC), .IW(IW)) u_prio (.req(active), .valid(win_v), .idx(win));
   always_comb begin
      state_n = state;
      idx_n = idx;
      take_ack = 1'b0;
      case (state)
         ST_IDLE: if (I_CLKEN && win_v) begin
            state_n = ST_REQ;
            idx_n = win;
         end
         ST_REQ: if (I_IACK) begin
            state_n = ST_HOLD;
            take_ack = 1'b1;
         end else if (I_CLKEN && !(|(active & sel))) state_n = ST_IDLE;
         ST_HOLD: if (I_CLKEN) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end
   // A fresh rising edge outranks any clear landing on the same cycle.
   assign clr = (take_ack ? sel : '0) | ((wr_en && I_A == ADDR_PEND) ? I_D[N_SRC-1:0] : '0);
   assign pend_n = (mode & ((pend & ~clr) | (I_SRC & ~src_q))) | (~mode & I_SRC);
   assign O_IRQ = state == ST_REQ;
   assign O_VECTOR = O_IRQ ? VEC_W'(VEC_BASE) + VEC_W'(idx) : '0;
   assign rd_data = I_A == ADDR_MASK ? 16'(mask) :
                    I_A == ADDR_MODE ? 16'(mode) :
                    I_A == ADDR_PEND ? 16'(pend) :
                    {O_IRQ, 8'h00, state, O_VECTOR};
   always_ff @(posedge I_CLK or posedge I_RESET)
      if (I_RESET) begin
         state <= ST_IDLE;
         idx <= '0;
         mask <= '0;
         mode <= '0;
         pend <= '0;
         src_q <= '0;
         O_ACK <= '0;
         O_D <= '0;
      end else begin
         state <= state_n;
         idx <= idx_n;
         pend <= pend_n;
         src_q <= I_SRC;
         O_ACK <= take_ack ? sel : '0;
         if (wr_en && I_A == ADDR_MASK) mask <= I_D[N_SRC-1:0];
         if (wr_en && I_A == ADDR_MODE) mode <= I_D[N_SRC-1:0];
         if (rd_en) O_D <= rd_data;
      end
endmodule
